conv_tile_sched: RTL and testbench

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

---
 rtl/conv_sched_pkg.sv | 17 +
 rtl/sched_perf_cnt.sv | 26 ++
 rtl/conv_tile_sched.sv | 186 ++++++++++++++++++
 tb/tb_conv_tile_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types for the conv tile scheduler: FSM state encoding, default index width, counter ceiling.
package conv_sched_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WLOAD = 3'd1,
      ILOAD = 3'd2,
      CONV  = 3'd3,
      DMA   = 3'd4,
      DONE  = 3'd5
   } sched_state_t;

endpackage

// File: rtl/sched_perf_cnt.sv
// Saturating 32-bit event counter with synchronous clear; 1-cycle update latency, never stalls.
module sched_perf_cnt
   import conv_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_clr,
   input  logic        i_inc,
   output logic [31:0] o_count
);

   logic [31:0] r_count;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != PERF_MAX)) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/conv_tile_sched.sv
// Layer tile sequencer (oc > h > ic loops); all handshake outputs registered, each phase waits on its ack.
// Optional utilisation counters built only when TILE_SCHED_PERF_EN is defined.
module conv_tile_sched
   import conv_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             layer_start,
   input  logic [CNT_W-1:0] cfg_h_tiles,
   input  logic [CNT_W-1:0] cfg_ic_tiles,
   input  logic [CNT_W-1:0] cfg_oc_tiles,
   output logic             weight_req,
   input  logic             weight_ack,
   output logic             input_loader_req,
   input  logic             input_ack,
   output logic             dataflow_en,
   input  logic             conv_done,
   output logic             dma_start,
   output logic             dma_last,
   input  logic             dma_done,
   output logic             layer_done,
   output logic             busy,
   output logic [CNT_W-1:0] cur_h,
   output logic [CNT_W-1:0] cur_ic,
   output logic [CNT_W-1:0] cur_oc,
   output logic [31:0]      perf_busy_cycles,
   output logic [31:0]      perf_conv_cycles
);

   // Configs are stored as last index so a zero count collapses to a single tile.
   function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] n);
      return (n == '0) ? '0 : n - CNT_W'(1);
   endfunction

   sched_state_t     r_state, w_nxt_state;
   logic [CNT_W-1:0] r_h_last, r_ic_last, r_oc_last;
   logic [CNT_W-1:0] r_cur_h, r_cur_ic, r_cur_oc;
   logic [CNT_W-1:0] w_nxt_h, w_nxt_ic, w_nxt_oc;
   logic             r_weight_req, r_input_req, r_dataflow_en;
   logic             r_dma_start, r_dma_last, r_layer_done, r_busy;
   logic             w_start_acc, w_dma_kick, w_dma_last;
   logic             w_h_is_last, w_ic_is_last, w_oc_is_last;

   assign w_start_acc  = (r_state == IDLE) && layer_start;
   assign w_h_is_last  = (r_cur_h  == r_h_last);
   assign w_ic_is_last = (r_cur_ic == r_ic_last);
   assign w_oc_is_last = (r_cur_oc == r_oc_last);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_h     = r_cur_h;
      w_nxt_ic    = r_cur_ic;
      w_nxt_oc    = r_cur_oc;
      w_dma_kick  = 1'b0;
      w_dma_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (layer_start) begin
               w_nxt_state = WLOAD;
               w_nxt_h     = '0;
               w_nxt_ic    = '0;
               w_nxt_oc    = '0;
            end
         end
         WLOAD: begin
            if (weight_ack) w_nxt_state = ILOAD;
         end
         ILOAD: begin
            if (input_ack) w_nxt_state = CONV;
         end
         CONV: begin
            if (conv_done) begin
               if (!w_ic_is_last) begin
                  w_nxt_ic    = r_cur_ic + CNT_W'(1);
                  w_nxt_state = WLOAD;
               end else begin
                  w_nxt_state = DMA;
                  w_dma_kick  = 1'b1;
                  w_dma_last  = w_h_is_last && w_oc_is_last;
               end
            end
         end
         DMA: begin
            if (dma_done) begin
               w_nxt_ic = '0;
               if (!w_h_is_last) begin
                  w_nxt_h     = r_cur_h + CNT_W'(1);
                  w_nxt_state = WLOAD;
               end else begin
                  w_nxt_h = '0;
                  if (!w_oc_is_last) begin
                     w_nxt_oc    = r_cur_oc + CNT_W'(1);
                     w_nxt_state = WLOAD;
                  end else begin
                     w_nxt_state = DONE;
                  end
               end
            end
         end
         DONE: begin
            w_nxt_state = IDLE;
         end
         default: begin
            w_nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_h_last  <= '0;
         r_ic_last <= '0;
         r_oc_last <= '0;
         r_cur_h   <= '0;
         r_cur_ic  <= '0;
         r_cur_oc  <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_cur_h  <= w_nxt_h;
         r_cur_ic <= w_nxt_ic;
         r_cur_oc <= w_nxt_oc;
         if (w_start_acc) begin
            r_h_last  <= last_idx(cfg_h_tiles);
            r_ic_last <= last_idx(cfg_ic_tiles);
            r_oc_last <= last_idx(cfg_oc_tiles);
         end
      end
   end

   // Outputs decode the next state so they line up with the state register without a comb path.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_weight_req  <= 1'b0;
         r_input_req   <= 1'b0;
         r_dataflow_en <= 1'b0;
         r_dma_start   <= 1'b0;
         r_dma_last    <= 1'b0;
         r_layer_done  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_weight_req  <= (w_nxt_state == WLOAD);
         r_input_req   <= (w_nxt_state == ILOAD);
         r_dataflow_en <= (w_nxt_state == CONV);
         r_dma_start   <= w_dma_kick;
         r_dma_last    <= w_dma_last;
         r_layer_done  <= (w_nxt_state == DONE);
         r_busy        <= (w_nxt_state != IDLE);
      end
   end

   assign weight_req       = r_weight_req;
   assign input_loader_req = r_input_req;
   assign dataflow_en      = r_dataflow_en;
   assign dma_start        = r_dma_start;
   assign dma_last         = r_dma_last;
   assign layer_done       = r_layer_done;
   assign busy             = r_busy;
   assign cur_h            = r_cur_h;
   assign cur_ic           = r_cur_ic;
   assign cur_oc           = r_cur_oc;

`ifdef TILE_SCHED_PERF_EN
   sched_perf_cnt u_perf_busy (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_start_acc),
      .i_inc   (r_busy),
      .o_count (perf_busy_cycles)
   );

   sched_perf_cnt u_perf_conv (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_start_acc),
      .i_inc   (r_dataflow_en),
      .o_count (perf_conv_cycles)
   );
`else
   assign perf_busy_cycles = '0;
   assign perf_conv_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboarded bench for conv_tile_sched: responder models the loaders/array/writer with tunable delays.
module tb_conv_tile_sched;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          layer_start = 1'b0;
   logic [W-1:0]  cfg_h_tiles = '0, cfg_ic_tiles = '0, cfg_oc_tiles = '0;
   logic          weight_ack = 1'b0, input_ack = 1'b0, conv_done = 1'b0, dma_done = 1'b0;
   logic          weight_req, input_loader_req, dataflow_en, dma_start, dma_last;
   logic          layer_done, busy;
   logic [W-1:0]  cur_h, cur_ic, cur_oc;
   logic [31:0]   perf_busy_cycles, perf_conv_cycles;

   conv_tile_sched #(.CNT_W(W)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .layer_start      (layer_start),
      .cfg_h_tiles      (cfg_h_tiles),
      .cfg_ic_tiles     (cfg_ic_tiles),
      .cfg_oc_tiles     (cfg_oc_tiles),
      .weight_req       (weight_req),
      .weight_ack       (weight_ack),
      .input_loader_req (input_loader_req),
      .input_ack        (input_ack),
      .dataflow_en      (dataflow_en),
      .conv_done        (conv_done),
      .dma_start        (dma_start),
      .dma_last         (dma_last),
      .dma_done         (dma_done),
      .layer_done       (layer_done),
      .busy             (busy),
      .cur_h            (cur_h),
      .cur_ic           (cur_ic),
      .cur_oc           (cur_oc),
      .perf_busy_cycles (perf_busy_cycles),
      .perf_conv_cycles (perf_conv_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] h;
      logic [W-1:0] ic;
      logic [W-1:0] oc;
   } tile_t;

   tile_t exp_tiles[$];
   logic  exp_last[$];
   tile_t t_pop;
   logic  l_pop;

   int errors = 0, checks = 0;
   int wdly = 1, idly = 1, cdly = 1, ddly = 1;
   int wcnt = 0, icnt = 0, ccnt = 0, dcnt = 0;
   bit dma_pend = 1'b0;
   int cyc = 0, wack_cyc = -1, ilr_cyc = -1;
   int n_wreq_pass, n_wreq_cyc, n_ilr_pass, n_conv_pass, n_dma, n_dma_last, n_ld, n_busy_cyc;
   logic p_wreq = 1'b0, p_ilr = 1'b0, p_den = 1'b0;

   // Responder first (drives acks for the coming edge), then monitor/scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (weight_req === 1'b1) wcnt++; else wcnt = 0;
      weight_ack = (weight_req === 1'b1) && (wcnt >= wdly);
      if (input_loader_req === 1'b1) icnt++; else icnt = 0;
      input_ack = (input_loader_req === 1'b1) && (icnt >= idly);
      if (dataflow_en === 1'b1) ccnt++; else ccnt = 0;
      conv_done = (dataflow_en === 1'b1) && (ccnt >= cdly);
      if (!rstn) dma_pend = 1'b0;
      if (dma_start === 1'b1) begin dma_pend = 1'b1; dcnt = 0; end
      dma_done = 1'b0;
      if (dma_pend) begin
         dcnt++;
         if (dcnt >= ddly) begin dma_done = 1'b1; dma_pend = 1'b0; end
      end

      if (weight_req === 1'b1 && !p_wreq) n_wreq_pass++;
      if (weight_req === 1'b1) n_wreq_cyc++;
      if (weight_req === 1'b1 && weight_ack && wack_cyc < 0) wack_cyc = cyc;
      if (input_loader_req === 1'b1 && !p_ilr) n_ilr_pass++;
      if (input_loader_req === 1'b1 && ilr_cyc < 0) ilr_cyc = cyc;
      if (dataflow_en === 1'b1 && !p_den) n_conv_pass++;
      if (busy === 1'b1) n_busy_cyc++;
      if (layer_done === 1'b1) n_ld++;

      if (dataflow_en === 1'b1 && conv_done) begin
         checks++;
         if (exp_tiles.size() == 0) begin
            errors++;
            $display("FAIL tile_order: got h=%0d ic=%0d oc=%0d, no tile expected", cur_h, cur_ic, cur_oc);
         end else begin
            t_pop = exp_tiles.pop_front();
            if ({cur_h, cur_ic, cur_oc} !== t_pop) begin
               errors++;
               $display("FAIL tile_order: got h=%0d ic=%0d oc=%0d, want h=%0d ic=%0d oc=%0d",
                        cur_h, cur_ic, cur_oc, t_pop.h, t_pop.ic, t_pop.oc);
            end
         end
      end
      if (dma_start === 1'b1) begin
         n_dma++;
         if (dma_last === 1'b1) n_dma_last++;
         checks++;
         if (exp_last.size() == 0) begin
            errors++;
            $display("FAIL dma_last: unexpected dma_start, dma_last=%b", dma_last);
         end else begin
            l_pop = exp_last.pop_front();
            if (dma_last !== l_pop) begin
               errors++;
               $display("FAIL dma_last: got %b want %b", dma_last, l_pop);
            end
         end
      end
      p_wreq = (weight_req === 1'b1);
      p_ilr  = (input_loader_req === 1'b1);
      p_den  = (dataflow_en === 1'b1);
   end

   task automatic clr_counts();
      n_wreq_pass = 0; n_wreq_cyc = 0; n_ilr_pass = 0; n_conv_pass = 0;
      n_dma = 0; n_dma_last = 0; n_ld = 0; n_busy_cyc = 0;
      wack_cyc = -1; ilr_cyc = -1;
   endtask

   // Pushes the expected tile/writer sequence, pulses layer_start, then scrambles cfg.
   task automatic start_layer(input int h, input int ic, input int oc);
      int eh, ei, eo;
      tile_t t;
      eh = (h == 0) ? 1 : h;
      ei = (ic == 0) ? 1 : ic;
      eo = (oc == 0) ? 1 : oc;
      for (int o = 0; o < eo; o++) begin
         for (int hh = 0; hh < eh; hh++) begin
            for (int i = 0; i < ei; i++) begin
               t.h = W'(hh); t.ic = W'(i); t.oc = W'(o);
               exp_tiles.push_back(t);
            end
            exp_last.push_back((hh == eh - 1) && (o == eo - 1));
         end
      end
      clr_counts();
      @(negedge clk); #1;
      cfg_h_tiles = W'(h); cfg_ic_tiles = W'(ic); cfg_oc_tiles = W'(oc);
      layer_start = 1'b1;
      @(negedge clk); #1;
      layer_start = 1'b0;
      cfg_h_tiles = 16'd5; cfg_ic_tiles = 16'd5; cfg_oc_tiles = 16'd5;
   endtask

   task automatic wait_done(input string nm, input int budget);
      for (int k = 0; k < budget && n_ld == 0; k++) begin
         @(negedge clk); #1;
      end
      checks++;
      if (n_ld == 0) begin
         errors++;
         $display("FAIL %s_timeout: no layer_done within %0d cycles", nm, budget);
      end
      repeat (4) begin @(negedge clk); #1; end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) begin @(negedge clk); #1; end
      checks++;
      if ({weight_req, input_loader_req, dataflow_en, dma_start, dma_last, layer_done, busy,
           cur_h, cur_ic, cur_oc, perf_busy_cycles, perf_conv_cycles} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b wreq=%b cur=%0d/%0d/%0d perf=%0d/%0d, want all 0",
                  busy, weight_req, cur_h, cur_ic, cur_oc, perf_busy_cycles, perf_conv_cycles);
      end
      rstn = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_single();
      start_layer(1, 1, 1);
      wait_done("single", 200);
      checks++; if (n_wreq_pass != 1) begin errors++; $display("FAIL single_wreq: got %0d want 1", n_wreq_pass); end
      checks++; if (n_ilr_pass != 1) begin errors++; $display("FAIL single_ilr: got %0d want 1", n_ilr_pass); end
      checks++; if (n_dma != 1 || n_dma_last != 1) begin errors++; $display("FAIL single_dma: got %0d/%0d want 1/1", n_dma, n_dma_last); end
      checks++; if (n_ld != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", n_ld); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_multi();
      start_layer(2, 3, 2);
      wait_done("multi", 1000);
      checks++; if (n_wreq_pass != 12) begin errors++; $display("FAIL multi_wreq: got %0d want 12", n_wreq_pass); end
      checks++; if (n_ilr_pass != 12) begin errors++; $display("FAIL multi_ilr: got %0d want 12", n_ilr_pass); end
      checks++; if (n_conv_pass != 12) begin errors++; $display("FAIL multi_conv: got %0d want 12", n_conv_pass); end
      checks++; if (n_dma != 4 || n_dma_last != 1) begin errors++; $display("FAIL multi_dma: got %0d/%0d want 4/1", n_dma, n_dma_last); end
      checks++; if (n_ld != 1) begin errors++; $display("FAIL multi_done: got %0d want 1", n_ld); end
      checks++; if (exp_tiles.size() != 0 || exp_last.size() != 0) begin
         errors++; $display("FAIL multi_leftover: tiles=%0d dmas=%0d want 0/0", exp_tiles.size(), exp_last.size());
      end
   endtask

   task automatic test_wack_delay();
      wdly = 5;
      start_layer(1, 1, 1);
      wait_done("wack", 300);
      wdly = 1;
      checks++; if (n_wreq_cyc != 5) begin errors++; $display("FAIL wack_hold: weight_req high %0d cycles want 5", n_wreq_cyc); end
      checks++; if (wack_cyc < 0 || ilr_cyc <= wack_cyc) begin
         errors++; $display("FAIL wack_order: ilr at %0d, ack at %0d, want ilr after ack", ilr_cyc, wack_cyc);
      end
      checks++; if (n_ld != 1) begin errors++; $display("FAIL wack_done: got %0d want 1", n_ld); end
   endtask

   task automatic test_zero_cfg();
      start_layer(0, 0, 0);
      @(negedge clk); #1;
      cfg_h_tiles = 16'd2; cfg_ic_tiles = 16'd3; cfg_oc_tiles = 16'd2;
      layer_start = 1'b1;
      @(negedge clk); #1;
      layer_start = 1'b0;
      wait_done("zero", 200);
      repeat (6) begin @(negedge clk); #1; end
      checks++; if (n_wreq_pass != 1 || n_ilr_pass != 1) begin
         errors++; $display("FAIL zero_passes: wreq=%0d ilr=%0d want 1/1", n_wreq_pass, n_ilr_pass);
      end
      checks++; if (n_dma != 1 || n_dma_last != 1) begin errors++; $display("FAIL zero_dma: got %0d/%0d want 1/1", n_dma, n_dma_last); end
      checks++; if (n_ld != 1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: pulses=%0d busy=%b want 1/0", n_ld, busy); end
   endtask

   task automatic test_mid_reset();
      bit found = 1'b0;
      cdly = 3;
      start_layer(2, 1, 2);
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk); #1;
         if (dataflow_en === 1'b1 && cur_h == 16'd1 && cur_ic == 16'd0 && cur_oc == 16'd1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach: tile h1/ic0/oc1 never seen in CONV"); end
      rstn = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({weight_req, input_loader_req, dataflow_en, dma_start, dma_last, layer_done, busy,
           cur_h, cur_ic, cur_oc, perf_busy_cycles, perf_conv_cycles} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: busy=%b den=%b cur=%0d/%0d/%0d, want all 0",
                  busy, dataflow_en, cur_h, cur_ic, cur_oc);
      end
      rstn = 1'b1;
      repeat (20) begin @(negedge clk); #1; end
      checks++; if (n_ld != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_nodone: pulses=%0d busy=%b want 0/0", n_ld, busy); end
      exp_tiles.delete();
      exp_last.delete();
      cdly = 1;
      start_layer(2, 1, 2);
      wait_done("midrst_rerun", 500);
      checks++; if (n_wreq_pass != 4 || n_dma != 4 || n_dma_last != 1) begin
         errors++; $display("FAIL midrst_rerun: wreq=%0d dma=%0d last=%0d want 4/4/1", n_wreq_pass, n_dma, n_dma_last);
      end
      checks++; if (exp_tiles.size() != 0) begin errors++; $display("FAIL midrst_leftover: tiles=%0d want 0", exp_tiles.size()); end
   endtask

   task automatic test_perf();
      int exp_busy, exp_conv;
      cdly = 10;
      start_layer(1, 1, 1);
      wait_done("perf", 300);
      cdly = 1;
      checks++; if (n_busy_cyc != 14) begin errors++; $display("FAIL perf_busy_obs: busy high %0d cycles want 14", n_busy_cyc); end
`ifdef TILE_SCHED_PERF_EN
      exp_busy = n_busy_cyc;
      exp_conv = 10;
`else
      exp_busy = 0;
      exp_conv = 0;
`endif
      checks++; if (perf_conv_cycles !== 32'(exp_conv)) begin
         errors++; $display("FAIL perf_conv: got %0d want %0d", perf_conv_cycles, exp_conv);
      end
      checks++; if (perf_busy_cycles !== 32'(exp_busy)) begin
         errors++; $display("FAIL perf_busy: got %0d want %0d", perf_busy_cycles, exp_busy);
      end
      start_layer(1, 1, 1);
      checks++; if (perf_busy_cycles !== 32'd0 || perf_conv_cycles !== 32'd0) begin
         errors++; $display("FAIL perf_clear: got %0d/%0d want 0/0", perf_busy_cycles, perf_conv_cycles);
      end
      wait_done("perf_rerun", 200);
   endtask

   initial begin
      clr_counts();
      test_reset();
      test_single();
      test_multi();
      test_wack_delay();
      test_zero_cfg();
      test_mid_reset();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
